// File: rtl/mmu_pkg.sv
// Shared MMU definitions: PTE bit positions, PPN field and page-table-walk responder states.
package mmu_pkg;

   localparam int unsigned PTE_VALID    = 31;
   localparam int unsigned PTE_USER     = 30;
   localparam int unsigned PTE_WRITE    = 29;
   localparam int unsigned PTE_EXEC     = 28;
   localparam int unsigned PTE_ACCESSED = 5;

   localparam int unsigned PTE_PPN_MSB  = 27;
   localparam int unsigned PTE_PPN_LSB  = 12;

   localparam logic [31:0] PTE_ACCESSED_MASK = 32'h1 << PTE_ACCESSED;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_WB_REQ,
      ST_RESP
   } ptw_state_e;

endpackage

// File: rtl/ptw_timeout_ctr.sv
// Bus-access watchdog: expired is high during the TIMEOUT_CYCLES-th enabled cycle after clear.
module ptw_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expired = enable && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pt_walk_responder.sv
// Memory-side responder for MMU page-table-walk reads: bus fetch, timeout, alignment and error flags.
// Optional accessed-bit writeback is enabled by defining PTW_ACCESSED_BIT_EN.
module pt_walk_responder
   import mmu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pt_addr,
   input  logic             pt_read,
   output logic [31:0]      pt_data,
   output logic             pt_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ack,
   output logic             err_timeout,
   output logic             err_overrun,
   output logic             err_align,
   input  logic             clr_err,
   output logic [CNT_W-1:0] walk_count
);

   ptw_state_e       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      pte_q, pte_d;
   logic [31:0]      pt_data_q, pt_data_d;
   logic             pt_ready_q, pt_ready_d;
   logic             mem_req_q, mem_req_d;
   logic             err_timeout_q, err_timeout_d;
   logic             err_overrun_q, err_overrun_d;
   logic             err_align_q, err_align_d;
   logic [CNT_W-1:0] walk_count_q, walk_count_d;
`ifdef PTW_ACCESSED_BIT_EN
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
`endif

   logic set_align, set_timeout, set_overrun;
   logic tmo_clear, tmo_enable, tmo_expired;

   ptw_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmo_clear),
      .enable (tmo_enable),
      .expired(tmo_expired)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      pte_d        = pte_q;
      pt_data_d    = pt_data_q;
      walk_count_d = walk_count_q;
      set_align    = 1'b0;
      set_timeout  = 1'b0;
      set_overrun  = pt_read && (state_q != ST_IDLE);
      tmo_clear    = 1'b0;
      tmo_enable   = (state_q == ST_RD_REQ) || (state_q == ST_WB_REQ);

      case (state_q)
         ST_IDLE: begin
            if (pt_read) begin
               addr_d = pt_addr;
               if (pt_addr[1:0] != 2'b00) begin
                  set_align = 1'b1;
                  pte_d     = '0;
                  state_d   = ST_RESP;
               end else begin
                  tmo_clear = 1'b1;
                  state_d   = ST_RD_REQ;
               end
            end
         end
         ST_RD_REQ: begin
            // ack beats an expiry landing in the same cycle
            if (mem_ack) begin
               pte_d   = mem_rdata;
               state_d = ST_RESP;
`ifdef PTW_ACCESSED_BIT_EN
               if (mem_rdata[PTE_VALID] && !mem_rdata[PTE_ACCESSED]) begin
                  pte_d     = mem_rdata | PTE_ACCESSED_MASK;
                  tmo_clear = 1'b1;
                  state_d   = ST_WB_REQ;
               end
`endif
            end else if (tmo_expired) begin
               pte_d       = '0;
               set_timeout = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_WB_REQ: begin
            if (mem_ack) begin
               state_d = ST_RESP;
            end else if (tmo_expired) begin
               set_timeout = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      pt_ready_d = (state_d == ST_RESP);
      if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
         pt_data_d = pte_d;
         if (walk_count_q != '1) begin
            walk_count_d = walk_count_q + 1'b1;
         end
      end
      mem_req_d = (state_d == ST_RD_REQ) || (state_d == ST_WB_REQ);

`ifdef PTW_ACCESSED_BIT_EN
      mem_we_d    = (state_d == ST_WB_REQ);
      mem_wdata_d = mem_wdata_q;
      if ((state_d == ST_WB_REQ) && (state_q != ST_WB_REQ)) begin
         mem_wdata_d = pte_d;
      end
`endif

      err_timeout_d = (err_timeout_q && !clr_err) || set_timeout;
      err_overrun_d = (err_overrun_q && !clr_err) || set_overrun;
      err_align_d   = (err_align_q   && !clr_err) || set_align;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         pte_q         <= '0;
         pt_data_q     <= '0;
         pt_ready_q    <= 1'b0;
         mem_req_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
         err_align_q   <= 1'b0;
         walk_count_q  <= '0;
`ifdef PTW_ACCESSED_BIT_EN
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= '0;
`endif
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         pte_q         <= pte_d;
         pt_data_q     <= pt_data_d;
         pt_ready_q    <= pt_ready_d;
         mem_req_q     <= mem_req_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
         err_align_q   <= err_align_d;
         walk_count_q  <= walk_count_d;
`ifdef PTW_ACCESSED_BIT_EN
         mem_we_q      <= mem_we_d;
         mem_wdata_q   <= mem_wdata_d;
`endif
      end
   end

   assign pt_data     = pt_data_q;
   assign pt_ready    = pt_ready_q;
   assign mem_req     = mem_req_q;
   assign mem_addr    = addr_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;
   assign err_align   = err_align_q;
   assign walk_count  = walk_count_q;
`ifdef PTW_ACCESSED_BIT_EN
   assign mem_we      = mem_we_q;
   assign mem_wdata   = mem_wdata_q;
`else
   assign mem_we      = 1'b0;
   assign mem_wdata   = '0;
`endif

endmodule

// File: tb/tb_pt_walk_responder.sv
// Self-checking bench for pt_walk_responder: directed vector table, corner sequences, random walks.
module tb_pt_walk_responder;

   localparam int unsigned TMO   = 255;
   localparam int unsigned CW    = 4;
   localparam int          NEVER = 999;
`ifdef PTW_ACCESSED_BIT_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   pt_addr;
   logic          pt_read;
   logic [31:0]   pt_data;
   logic          pt_ready;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ack;
   logic          err_timeout;
   logic          err_overrun;
   logic          err_align;
   logic          clr_err;
   logic [CW-1:0] walk_count;

   pt_walk_responder #(
      .TIMEOUT_CYCLES(TMO),
      .CNT_W         (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pt_addr    (pt_addr),
      .pt_read    (pt_read),
      .pt_data    (pt_data),
      .pt_ready   (pt_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .err_timeout(err_timeout),
      .err_overrun(err_overrun),
      .err_align  (err_align),
      .clr_err    (clr_err),
      .walk_count (walk_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_count = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      int          rd_dly;
      int          wb_dly;
      int          dup;
      logic [31:0] exp_pte;
      int          exp_ready;
      bit          exp_wb;
      bit          exp_tmo;
      bit          exp_align;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic int sat_inc(input int c);
      return (c >= (1 << CW) - 1) ? c : c + 1;
   endfunction

   // Reference behaviour for one walk, computed from the responder rules.
   task automatic model(input logic [31:0] addr, input logic [31:0] rdata, input int rd_dly,
                        input int wb_dly, output vec_t v);
      int rd_len, wb_len;
      v.addr = addr; v.rdata = rdata; v.rd_dly = rd_dly; v.wb_dly = wb_dly; v.dup = 0;
      v.exp_wb = 0; v.exp_tmo = 0; v.exp_align = (addr % 4) != 0;
      if (v.exp_align) begin
         v.exp_pte = 0; v.exp_ready = 1;
      end else if (rd_dly >= int'(TMO)) begin
         v.exp_pte = 0; v.exp_tmo = 1; v.exp_ready = 1 + int'(TMO);
      end else begin
         rd_len = rd_dly + 1;
         v.exp_pte = rdata;
         v.exp_ready = 1 + rd_len;
         if (WB_EN && rdata[31] && !rdata[5]) begin
            v.exp_wb  = 1;
            v.exp_pte = rdata + 32'h20;
            wb_len    = (wb_dly >= int'(TMO)) ? int'(TMO) : wb_dly + 1;
            v.exp_tmo = wb_dly >= int'(TMO);
            v.exp_ready = 1 + rd_len + wb_len;
         end
      end
   endtask

   task automatic clear_errors();
      @(negedge clk); clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      check("err_cleared", {29'd0, err_timeout, err_overrun, err_align}, 32'd0);
   endtask

   task automatic do_walk(input vec_t v);
      int c = 1, rd_n = 0, wb_n = 0, ready_n = 0, ready_c = -1;
      int exp_rd, exp_wbn;
      logic [31:0] data_at = 'x, data_next = 'x, wdata_seen = 'x;
      logic ready_next = 1'bx;
      bit addr_ok = 1, done = 0;
      @(negedge clk); pt_addr = v.addr; pt_read = 1'b1;
      @(negedge clk); pt_read = 1'b0;
      while (!done && c < 700) begin
         pt_read = 1'b0;
         mem_ack = 1'b0;
         if (mem_req) begin
            if (mem_addr !== v.addr) addr_ok = 0;
            if (!mem_we) begin
               mem_ack = (rd_n == v.rd_dly);
               mem_rdata = v.rdata;
               rd_n++;
            end else begin
               mem_ack = (wb_n == v.wb_dly);
               mem_rdata = $urandom;
               wdata_seen = mem_wdata;
               wb_n++;
            end
         end
         if (ready_c >= 0 && c == ready_c + 1) begin
            ready_next = pt_ready; data_next = pt_data; done = 1;
         end else if (pt_ready) begin
            ready_n++; ready_c = c; data_at = pt_data;
         end
         if (c == v.dup) begin
            pt_read = 1'b1; pt_addr = v.addr ^ 32'h0000_0100;
         end
         if (!done) begin
            @(negedge clk); c++;
         end
      end
      pt_read = 1'b0; mem_ack = 1'b0;
      exp_rd  = v.exp_align ? 0 : ((v.rd_dly >= int'(TMO)) ? int'(TMO) : v.rd_dly + 1);
      exp_wbn = !v.exp_wb ? 0 : ((v.wb_dly >= int'(TMO)) ? int'(TMO) : v.wb_dly + 1);
      exp_count = sat_inc(exp_count);
      check("ready_cycle", ready_c, v.exp_ready);
      check("ready_width", {31'd0, ready_next}, 32'd0);
      check("pt_data", data_at, v.exp_pte);
      check("pt_data_hold", data_next, v.exp_pte);
      check("rd_req_cycles", rd_n, exp_rd);
      check("wb_req_cycles", wb_n, exp_wbn);
      if (v.exp_wb) check("wb_data", wdata_seen, v.exp_pte);
      check("mem_addr", {31'd0, addr_ok}, 32'd1);
      check("walk_count", 32'(walk_count), exp_count);
      check("err_flags", {29'd0, err_timeout, err_overrun, err_align},
            {29'd0, v.exp_tmo, v.dup != 0, v.exp_align});
      clear_errors();
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; pt_addr = '0; pt_read = 1'b0; mem_rdata = '0; mem_ack = 1'b0; clr_err = 1'b0;

      vecs[0] = '{32'h0000_1004, 32'hA000_3020, 3, 0, 0, 32'hA000_3020, 5, 0, 0, 0};
      vecs[1] = '{32'h0000_1006, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 1, 0, 0, 1};
      vecs[2] = '{32'h0000_2000, 32'h1111_1111, NEVER, 0, 0, 32'h0, 256, 0, 1, 0};
      vecs[3] = '{32'h0000_3000, 32'h1234_5678, 1, 0, 2, 32'h1234_5678, 3, 0, 0, 0};
      vecs[4] = WB_EN ? '{32'h0000_4000, 32'h8000_5000, 0, 2, 0, 32'h8000_5020, 5, 1, 0, 0}
                      : '{32'h0000_4000, 32'h8000_5000, 0, 2, 0, 32'h8000_5000, 2, 0, 0, 0};
      vecs[5] = '{32'h0000_4004, 32'h8000_5020, 0, 0, 0, 32'h8000_5020, 2, 0, 0, 0};
      vecs[6] = '{32'h0000_6000, 32'h0000_0001, 254, 0, 0, 32'h0000_0001, 256, 0, 0, 0};
      vecs[7] = '{32'h0000_5000, 32'h0BAD_F00D, 0, 0, 2, 32'h0BAD_F00D, 2, 0, 0, 0};
      vecs[8] = WB_EN ? '{32'h0000_7000, 32'h8000_0000, 0, NEVER, 0, 32'h8000_0020, 257, 1, 1, 0}
                      : '{32'h0000_7000, 32'h8000_0000, 0, NEVER, 0, 32'h8000_0000, 2, 0, 0, 0};
      vecs[9] = '{32'h0000_0003, 32'h0, 0, 0, 1, 32'h0, 1, 0, 0, 1};

      #1;
      check("reset_outputs", {pt_ready, mem_req, mem_we, err_timeout, err_overrun, err_align},
            6'd0);
      check("reset_data", pt_data | mem_addr | mem_wdata | 32'(walk_count), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) do_walk(vecs[i]);

      // clear coincident with a new alignment error: the set must survive
      @(negedge clk); pt_addr = 32'h0000_7001; pt_read = 1'b1; clr_err = 1'b1;
      @(negedge clk); pt_read = 1'b0; clr_err = 1'b0;
      check("clr_vs_set_align", {31'd0, err_align}, 32'd1);
      check("clr_vs_set_ready", {31'd0, pt_ready}, 32'd1);
      exp_count = sat_inc(exp_count);
      @(negedge clk);
      check("clr_vs_set_count", 32'(walk_count), exp_count);
      clear_errors();

      // reset in the middle of a read: request drops at once, no response follows
      @(negedge clk); pt_addr = 32'h0000_8000; pt_read = 1'b1;
      @(negedge clk); pt_read = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rd_req", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rst_req_drop", {31'd0, mem_req}, 32'd0);
      check("rst_count", 32'(walk_count), 32'd0);
      exp_count = 0;
      @(negedge clk); rst_n = 1'b1;
      begin
         int seen = 0;
         repeat (5) begin
            @(negedge clk);
            if (pt_ready || mem_req) seen++;
         end
         check("rst_no_response", seen, 0);
      end

      // random walks against the reference model
      for (int n = 0; n < 30; n++) begin
         logic [31:0] a, d;
         int rd, wb;
         a  = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         d  = $urandom;
         rd = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 6));
         wb = int'($urandom_range(0, 4));
         model(a, d, rd, wb, v);
         do_walk(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
